counter_auto_ctrl: RTL and testbench

Sequencing controller for the 4-bit LED counter. It accepts single-cycle button pulses, arbitrates between simultaneous requests, and adds two auto-count modes that step the count once per second from an internal divider. It sits between the button conditioning logic (debounce and edge detect) and the LEDs, and owns the count register.

---
 rtl/counter_pkg.sv | 25 ++
 rtl/counter_auto_ctrl_second_ticker.sv | 29 ++
 rtl/counter_auto_ctrl.sv | 74 +++++++
 tb/tb_counter_auto_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared mode encoding, button bit positions and the mode-advance rule
// for the LED counter sequencing controller.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL    = 2'd0,
    MODE_AUTO_UP   = 2'd1,
    MODE_AUTO_DOWN = 2'd2
  } mode_e;

  localparam int BTN_INC  = 0;
  localparam int BTN_DEC  = 1;
  localparam int BTN_MODE = 2;
  localparam int BTN_CLR  = 3;

  // The unused encoding 2'd3 falls back to MANUAL so the FSM cannot stick.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_MANUAL:    next_mode = MODE_AUTO_UP;
      MODE_AUTO_UP:   next_mode = MODE_AUTO_DOWN;
      default:        next_mode = MODE_MANUAL;
    endcase
  endfunction

endpackage

// File: rtl/counter_auto_ctrl_second_ticker.sv
// Free-running divider that flags the last cycle of each auto-step period.
// Held at zero while disabled and restarted by clr.
module second_ticker #(
  parameter int CYCLES_PER_SECOND = 125_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic done
);

  localparam int DIV_W = $clog2(CYCLES_PER_SECOND);
  localparam logic [DIV_W-1:0] TERMINAL = DIV_W'(CYCLES_PER_SECOND - 1);

  logic [DIV_W-1:0] div_reg;

  assign done = en && (div_reg == TERMINAL);

  // Wrapping on done also covers the case where clr suppresses the step.
  always_ff @(posedge clk) begin
    if (rst || clr || !en || done) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

endmodule

// File: rtl/counter_auto_ctrl.sv
// LED counter controller: one-hot-priority button arbiter, mode FSM and the
// count/tick registers, with auto stepping paced by second_ticker.
module counter_auto_ctrl
  import counter_pkg::*;
#(
  parameter int CYCLES_PER_SECOND = 125_000_000,
  parameter int WIDTH             = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       buttons,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       mode,
  output logic             tick
);

  logic [WIDTH-1:0] count_reg, count_next;
  mode_e            mode_reg, mode_next;
  logic             tick_reg, tick_next;
  logic             btn_accepted;
  logic             step_due;

  assign btn_accepted = |buttons;

  second_ticker #(
    .CYCLES_PER_SECOND(CYCLES_PER_SECOND)
  ) u_ticker (
    .clk (clk),
    .rst (rst),
    .en  (mode_reg != MODE_MANUAL),
    .clr (btn_accepted),
    .done(step_due)
  );

  // Lowest set button index wins; a due auto step only applies when no button does.
  always_comb begin
    count_next = count_reg;
    mode_next  = mode_reg;
    tick_next  = 1'b0;
    if (buttons[BTN_INC]) begin
      count_next = count_reg + WIDTH'(1);
    end else if (buttons[BTN_DEC]) begin
      count_next = count_reg - WIDTH'(1);
    end else if (buttons[BTN_MODE]) begin
      mode_next = next_mode(mode_reg);
    end else if (buttons[BTN_CLR]) begin
      count_next = '0;
    end else if (step_due) begin
      tick_next = 1'b1;
      if (mode_reg == MODE_AUTO_UP) begin
        count_next = count_reg + WIDTH'(1);
      end else begin
        count_next = count_reg - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      mode_reg  <= MODE_MANUAL;
      tick_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      mode_reg  <= mode_next;
      tick_reg  <= tick_next;
    end
  end

  assign count = count_reg;
  assign mode  = mode_reg;
  assign tick  = tick_reg;

endmodule

// File: tb/tb_counter_auto_ctrl.sv
// Directed bench for counter_auto_ctrl with a deadline-based reference model
// checked every cycle, plus literal expectations at the key scenario points.
`timescale 1ns/1ps
module tb_counter_auto_ctrl;

  localparam int CPS   = 4;
  localparam int WIDTH = 4;
  localparam int MODN  = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       buttons = 4'b0000;
  logic [WIDTH-1:0] count;
  logic [1:0]       mode;
  logic             tick;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  counter_auto_ctrl #(
    .CYCLES_PER_SECOND(CPS),
    .WIDTH(WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .buttons(buttons),
    .count(count),
    .mode(mode),
    .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference model: each accepted action or step schedules the next step
  // CPS edges later; a step happens only if nothing else wins that edge.
  int m_count = 0;
  int m_mode  = 0;
  int m_tick  = 0;
  int edge_n  = 0;
  int due     = 0;

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (rst) begin
      m_count = 0;
      m_mode  = 0;
      m_tick  = 0;
    end else if (buttons != 4'b0000) begin
      m_tick = 0;
      due    = edge_n + CPS;
      if (buttons[0])      m_count = (m_count + 1) % MODN;
      else if (buttons[1]) m_count = (m_count + MODN - 1) % MODN;
      else if (buttons[2]) m_mode  = (m_mode + 1) % 3;
      else                 m_count = 0;
    end else if (m_mode != 0 && edge_n == due) begin
      m_tick  = 1;
      due     = edge_n + CPS;
      m_count = (m_mode == 1) ? (m_count + 1) % MODN : (m_count + MODN - 1) % MODN;
    end else begin
      m_tick = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks = checks + 1;
      if (count !== m_count[WIDTH-1:0] || mode !== m_mode[1:0] || tick !== m_tick[0]) begin
        errors = errors + 1;
        $display("FAIL model t=%0t: got count=%0d mode=%0d tick=%0d, want count=%0d mode=%0d tick=%0d",
                 $time, count, mode, tick, m_count, m_mode, m_tick);
      end
    end
  end

  task automatic cyc(input logic [3:0] b, input logic r);
    buttons = b;
    rst     = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'b0000, 1'b0);
  endtask

  task automatic expect_lit(input string name, input int c, input int m, input int t);
    checks = checks + 1;
    if (count !== c[WIDTH-1:0] || mode !== m[1:0] || tick !== t[0]) begin
      errors = errors + 1;
      $display("FAIL %s: got count=%0d mode=%0d tick=%0d, want count=%0d mode=%0d tick=%0d",
               name, count, mode, tick, c, m, t);
    end else begin
      $display("ok   %s: count=%0d mode=%0d tick=%0d", name, count, mode, tick);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    cyc(4'b1111, 1'b1);
    cyc(4'b1111, 1'b1);
    expect_lit("reset", 0, 0, 0);
    chk_on = 1'b1;

    // Manual mode
    cyc(4'b0001, 1'b0); cyc(4'b0001, 1'b0); cyc(4'b0001, 1'b0);
    cyc(4'b0010, 1'b0);
    expect_lit("inc3_dec1", 2, 0, 0);
    cyc(4'b1000, 1'b0);
    expect_lit("clear", 0, 0, 0);
    cyc(4'b0010, 1'b0);
    expect_lit("dec_wrap", 15, 0, 0);
    cyc(4'b0001, 1'b0);
    expect_lit("inc_wrap", 0, 0, 0);

    // Auto up
    cyc(4'b0100, 1'b0);
    expect_lit("enter_up", 0, 1, 0);
    idle(3);
    expect_lit("up_before_step", 0, 1, 0);
    idle(1);
    expect_lit("up_step1", 1, 1, 1);
    idle(1);
    expect_lit("up_tick_drop", 1, 1, 0);
    idle(3);
    expect_lit("up_step2", 2, 1, 1);
    cyc(4'b0010, 1'b0); cyc(4'b0010, 1'b0); cyc(4'b0010, 1'b0);
    expect_lit("up_at_15", 15, 1, 0);
    idle(3);
    expect_lit("up_hold_15", 15, 1, 0);
    idle(1);
    expect_lit("up_wrap", 0, 1, 1);

    // Collision in auto down
    cyc(4'b0100, 1'b0);
    expect_lit("enter_down", 0, 2, 0);
    for (int i = 0; i < 5; i++) cyc(4'b0001, 1'b0);
    expect_lit("down_at_5", 5, 2, 0);
    idle(3);
    cyc(4'b0001, 1'b0);
    expect_lit("collision", 6, 2, 0);
    idle(3);
    expect_lit("after_collision_hold", 6, 2, 0);
    idle(1);
    expect_lit("after_collision_step", 5, 2, 1);

    // Priority
    cyc(4'b0100, 1'b0);
    cyc(4'b0010, 1'b0); cyc(4'b0010, 1'b0);
    expect_lit("manual_at_3", 3, 0, 0);
    cyc(4'b0110, 1'b0);
    expect_lit("prio_dec_over_mode", 2, 0, 0);
    cyc(4'b1100, 1'b0);
    expect_lit("prio_mode_over_clr", 2, 1, 0);
    cyc(4'b1000, 1'b0);
    expect_lit("clr_keeps_mode", 0, 1, 0);

    // Mode wrap, then idle in manual
    cyc(4'b0100, 1'b0); cyc(4'b0100, 1'b0);
    cyc(4'b0001, 1'b0); cyc(4'b0001, 1'b0);
    cyc(4'b0100, 1'b0); cyc(4'b0100, 1'b0); cyc(4'b0100, 1'b0);
    expect_lit("mode_wrap", 2, 0, 0);
    idle(20);
    expect_lit("manual_idle20", 2, 0, 0);

    // Reset mid-period and on the due edge
    cyc(4'b0100, 1'b0);
    idle(2);
    cyc(4'b0000, 1'b1);
    expect_lit("rst_mid_period", 0, 0, 0);
    idle(6);
    expect_lit("rst_no_tick", 0, 0, 0);
    cyc(4'b0001, 1'b0);
    cyc(4'b0100, 1'b0);
    idle(3);
    cyc(4'b0000, 1'b1);
    expect_lit("rst_on_due_edge", 0, 0, 0);
    idle(2);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
